motor_step_sequencer: RTL and testbench

- Six-step (trapezoidal) commutation controller for the 3-phase motor bridge.
- Gates the 100 Hz tick divider through workingO, and consumes its one-cycle tick pulse.
- Sequences rotor alignment, an open-loop acceleration ramp and steady run, then drives the six bridge gate enables with dead-time insertion.
- Handles start, stop and fault commands from the control front end.

---
 rtl/motor_step_sequencer.sv | 164 ++++++++++++++++
 tb/tb_motor_step_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_sequencer.sv
// Six-step trapezoidal commutation: align, open-loop ramp, run; dead-time on every gate pattern change.
// Registered outputs, one-cycle latency from inputs; fault clears gates immediately with no dead window.
module motor_step_sequencer #(
  parameter int START_DIV   = 20,
  parameter int RUN_DIV     = 4,
  parameter int ALIGN_TICKS = 50,
  parameter int DEAD_CYC    = 8,
  parameter int DIV_W       = 8
) (
  input  logic       clkI,
  input  logic       nRstI,
  input  logic       startI,
  input  logic       stopI,
  input  logic       dirI,
  input  logic       faultI,
  input  logic       tickI,
  output logic       workingO,
  output logic [2:0] phaseHiO,
  output logic [2:0] phaseLoO,
  output logic [2:0] stepO,
  output logic [2:0] stateO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [DW-1:0]    DEAD_LD  = DW'(DEAD_CYC);
  localparam logic [DW-1:0]    DEAD_ONE = DW'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_START = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] DIV_RUN   = DIV_W'(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_ALIGN = DIV_W'(ALIGN_TICKS);

  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] cur_div;
  logic [DW-1:0]    dead_cnt;
  logic             dir_lat;

  logic [DIV_W-1:0] tick_lim;
  logic [DIV_W-1:0] lim_m1;
  logic [DIV_W-1:0] div_dec;
  logic [2:0]       step_nxt;
  logic             active;
  logic             adv;

  // Step -> {hi, lo}; each entry drives exactly one high and one different low leg.
  function automatic logic [5:0] gate_pat(input logic [2:0] s);
    case (s)
      3'd0:    gate_pat = {3'b001, 3'b010};
      3'd1:    gate_pat = {3'b001, 3'b100};
      3'd2:    gate_pat = {3'b010, 3'b100};
      3'd3:    gate_pat = {3'b010, 3'b001};
      3'd4:    gate_pat = {3'b100, 3'b001};
      3'd5:    gate_pat = {3'b100, 3'b010};
      default: gate_pat = 6'b000000;
    endcase
  endfunction

  assign active   = (stateO == S_ALIGN) || (stateO == S_RAMP) || (stateO == S_RUN);
  assign tick_lim = (stateO == S_ALIGN) ? DIV_ALIGN : cur_div;
  assign lim_m1   = tick_lim - DIV_ONE;
  assign div_dec  = cur_div - DIV_ONE;
  assign adv      = active && tickI && (tick_cnt == lim_m1);

  always_comb begin
    step_nxt = stepO;
    if (dir_lat) step_nxt = (stepO == 3'd5) ? 3'd0 : stepO + 3'd1;
    else         step_nxt = (stepO == 3'd0) ? 3'd5 : stepO - 3'd1;
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      stateO   <= S_IDLE;
      stepO    <= 3'd0;
      phaseHiO <= 3'b000;
      phaseLoO <= 3'b000;
      workingO <= 1'b0;
      tick_cnt <= '0;
      cur_div  <= DIV_START;
      dead_cnt <= '0;
      dir_lat  <= 1'b0;
    end else if (faultI) begin
      stateO   <= S_FAULT;
      phaseHiO <= 3'b000;
      phaseLoO <= 3'b000;
      workingO <= 1'b0;
      dead_cnt <= '0;
    end else begin
      case (stateO)
        S_IDLE: begin
          if (startI && !stopI) begin
            stateO   <= S_ALIGN;
            dir_lat  <= dirI;
            stepO    <= 3'd0;
            cur_div  <= DIV_START;
            tick_cnt <= '0;
            phaseHiO <= 3'b000;
            phaseLoO <= 3'b000;
            dead_cnt <= DEAD_LD;
            workingO <= 1'b1;
          end
        end
        S_FAULT: begin
          if (stopI) stateO <= S_IDLE;
        end
        S_STOP: begin
          if (dead_cnt <= DEAD_ONE) begin
            stateO   <= S_IDLE;
            dead_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt - DEAD_ONE;
          end
        end
        S_ALIGN, S_RAMP, S_RUN: begin
          if (stopI) begin
            stateO   <= S_STOP;
            phaseHiO <= 3'b000;
            phaseLoO <= 3'b000;
            workingO <= 1'b0;
            dead_cnt <= DEAD_LD;
          end else if (adv) begin
            // A fresh advance restarts the dead window even if one is still running.
            tick_cnt <= '0;
            stepO    <= step_nxt;
            phaseHiO <= 3'b000;
            phaseLoO <= 3'b000;
            dead_cnt <= DEAD_LD;
            if (stateO == S_ALIGN) begin
              stateO <= S_RAMP;
            end else if (stateO == S_RAMP) begin
              if (cur_div == DIV_RUN) begin
                stateO <= S_RUN;
              end else begin
                cur_div <= div_dec;
                if (div_dec == DIV_RUN) stateO <= S_RUN;
              end
            end
          end else begin
            if (tickI) tick_cnt <= tick_cnt + DIV_ONE;
            if (dead_cnt == DEAD_ONE) begin
              {phaseHiO, phaseLoO} <= gate_pat(stepO);
              dead_cnt <= '0;
            end else if (dead_cnt != '0) begin
              dead_cnt <= dead_cnt - DEAD_ONE;
            end
          end
        end
        default: begin
          stateO   <= S_IDLE;
          phaseHiO <= 3'b000;
          phaseLoO <= 3'b000;
          workingO <= 1'b0;
          dead_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_step_sequencer.sv
// Directed bench for motor_step_sequencer with a 20-cycle tick divider model gated by workingO.
module tb_motor_step_sequencer;

  logic       clkI = 1'b0;
  logic       nRstI = 1'b0;
  logic       startI = 1'b0;
  logic       stopI = 1'b0;
  logic       dirI = 1'b0;
  logic       faultI = 1'b0;
  logic       tickI = 1'b0;
  logic       workingO;
  logic [2:0] phaseHiO, phaseLoO, stepO, stateO;

  int checks = 0;
  int failures = 0;
  int tick_total = 0;
  int div_cnt = 0;
  int overlap_seen = 0;

  motor_step_sequencer #(
    .START_DIV(4), .RUN_DIV(2), .ALIGN_TICKS(3), .DEAD_CYC(8), .DIV_W(8)
  ) dut (
    .clkI(clkI), .nRstI(nRstI), .startI(startI), .stopI(stopI), .dirI(dirI),
    .faultI(faultI), .tickI(tickI), .workingO(workingO), .phaseHiO(phaseHiO),
    .phaseLoO(phaseLoO), .stepO(stepO), .stateO(stateO)
  );

  always #5 clkI = ~clkI;

  // Divider model: held in reload while workingO is low, one-cycle pulse every 20 cycles otherwise.
  initial begin
    forever begin
      @(negedge clkI);
      if (!workingO) begin
        div_cnt = 0;
        tickI = 1'b0;
      end else begin
        div_cnt++;
        if (div_cnt == 20) begin
          div_cnt = 0;
          tickI = 1'b1;
          tick_total++;
        end else begin
          tickI = 1'b0;
        end
      end
    end
  end

  always @(negedge clkI) begin
    if ((phaseHiO & phaseLoO) != 3'b000) overlap_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic start_motor(input logic dir);
    @(negedge clkI);
    dirI = dir;
    startI = 1'b1;
    @(negedge clkI);
    startI = 1'b0;
  endtask

  task automatic wait_step(output int nt, output bit ok);
    logic [2:0] s0;
    int t0;
    s0 = stepO;
    t0 = tick_total;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkI);
      if (stepO !== s0) begin
        ok = 1'b1;
        break;
      end
    end
    nt = tick_total - t0;
  endtask

  // Counts gate-off cycles starting at the current cycle, then returns the pattern one cycle later.
  task automatic observe_window(output int zc, output logic [2:0] hi, output logic [2:0] lo);
    zc = ((phaseHiO | phaseLoO) == 3'b000) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clkI);
      if ((phaseHiO | phaseLoO) == 3'b000) zc++;
    end
    @(negedge clkI);
    hi = phaseHiO;
    lo = phaseLoO;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clkI);
    checks++;
    if ({stateO, stepO, phaseHiO, phaseLoO, workingO} !== 13'd0)
      $display("FAIL reset_outputs got state=%0d step=%0d hi=%b lo=%b working=%b required all 0",
               stateO, stepO, phaseHiO, phaseLoO, workingO);
    nRstI = 1'b1;
    @(negedge clkI);
    checks++;
    if (stateO !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle got=%0d required=0", stateO);
    end
  endtask

  task automatic test_align;
    int zc, nt;
    bit ok;
    logic [2:0] hi, lo;
    start_motor(1'b1);
    checks++;
    if (stateO !== 3'd1 || workingO !== 1'b1) begin
      failures++;
      $display("FAIL align_entry got state=%0d working=%b required 1/1", stateO, workingO);
    end
    observe_window(zc, hi, lo);
    checks++;
    if (zc !== 8 || hi !== 3'b001 || lo !== 3'b010) begin
      failures++;
      $display("FAIL align_dead got zero=%0d hi=%b lo=%b required 8 001 010", zc, hi, lo);
    end
    wait_step(nt, ok);
    checks++;
    if (!ok || nt !== 3 || stepO !== 3'd1 || stateO !== 3'd2) begin
      failures++;
      $display("FAIL align_exit got ok=%0d ticks=%0d step=%0d state=%0d required 1 3 1 2",
               ok, nt, stepO, stateO);
    end
    observe_window(zc, hi, lo);
    checks++;
    if (zc !== 8 || hi !== 3'b001 || lo !== 3'b100) begin
      failures++;
      $display("FAIL ramp_first_dead got zero=%0d hi=%b lo=%b required 8 001 100", zc, hi, lo);
    end
  endtask

  task automatic test_forward_ramp;
    logic [2:0] e_step [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    int         e_tick [6] = '{4, 3, 2, 2, 2, 2};
    logic [2:0] e_st   [6] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    logic [2:0] e_hi   [6] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    logic [2:0] e_lo   [6] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
    int zc, nt;
    bit ok;
    logic [2:0] hi, lo;
    for (int i = 0; i < 6; i++) begin
      wait_step(nt, ok);
      checks++;
      if (!ok || nt !== e_tick[i] || stepO !== e_step[i] || stateO !== e_st[i]) begin
        failures++;
        $display("FAIL fwd_step%0d got ok=%0d ticks=%0d step=%0d state=%0d required ticks=%0d step=%0d state=%0d",
                 i, ok, nt, stepO, stateO, e_tick[i], e_step[i], e_st[i]);
      end
      observe_window(zc, hi, lo);
      checks++;
      if (zc !== 8 || hi !== e_hi[i] || lo !== e_lo[i]) begin
        failures++;
        $display("FAIL fwd_gate%0d got zero=%0d hi=%b lo=%b required 8 %b %b",
                 i, zc, hi, lo, e_hi[i], e_lo[i]);
      end
    end
  endtask

  task automatic test_stop;
    logic [2:0] held;
    int bad;
    held = stepO;
    stopI = 1'b1;
    @(negedge clkI);
    stopI = 1'b0;
    checks++;
    if (stateO !== 3'd4 || phaseHiO !== 3'b000 || phaseLoO !== 3'b000 || workingO !== 1'b0) begin
      failures++;
      $display("FAIL stop_entry got state=%0d hi=%b lo=%b working=%b required 4 000 000 0",
               stateO, phaseHiO, phaseLoO, workingO);
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clkI);
      if (stateO !== 3'd4) bad++;
    end
    @(negedge clkI);
    checks++;
    if (bad !== 0 || stateO !== 3'd0) begin
      failures++;
      $display("FAIL stop_length got early_exits=%0d final_state=%0d required 0 0", bad, stateO);
    end
    checks++;
    if (stepO !== held) begin
      failures++;
      $display("FAIL stop_step_hold got=%0d required=%0d", stepO, held);
    end
    startI = 1'b1;
    stopI = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clkI);
      if (stateO !== 3'd0) bad++;
    end
    startI = 1'b0;
    stopI = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL start_stop_idle got non_idle_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_reverse;
    logic [2:0] e_step [6] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    int         e_tick [6] = '{3, 4, 3, 2, 2, 2};
    logic [2:0] e_st   [6] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
    logic [2:0] e_hi   [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    logic [2:0] e_lo   [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};
    int zc, nt;
    bit ok;
    logic [2:0] hi, lo;
    start_motor(1'b0);
    checks++;
    if (stateO !== 3'd1 || stepO !== 3'd0) begin
      failures++;
      $display("FAIL rev_entry got state=%0d step=%0d required 1 0", stateO, stepO);
    end
    observe_window(zc, hi, lo);
    checks++;
    if (zc !== 8 || hi !== 3'b001 || lo !== 3'b010) begin
      failures++;
      $display("FAIL rev_align_gate got zero=%0d hi=%b lo=%b required 8 001 010", zc, hi, lo);
    end
    for (int i = 0; i < 6; i++) begin
      wait_step(nt, ok);
      checks++;
      if (!ok || nt !== e_tick[i] || stepO !== e_step[i] || stateO !== e_st[i]) begin
        failures++;
        $display("FAIL rev_step%0d got ok=%0d ticks=%0d step=%0d state=%0d required ticks=%0d step=%0d state=%0d",
                 i, ok, nt, stepO, stateO, e_tick[i], e_step[i], e_st[i]);
      end
      observe_window(zc, hi, lo);
      checks++;
      if (zc !== 8 || hi !== e_hi[i] || lo !== e_lo[i]) begin
        failures++;
        $display("FAIL rev_gate%0d got zero=%0d hi=%b lo=%b required 8 %b %b",
                 i, zc, hi, lo, e_hi[i], e_lo[i]);
      end
      if (i == 2) dirI = 1'b1;
    end
    stopI = 1'b1;
    repeat (12) @(negedge clkI);
    stopI = 1'b0;
  endtask

  task automatic test_fault;
    int nt, bad;
    bit ok;
    start_motor(1'b1);
    wait_step(nt, ok);
    faultI = 1'b1;
    stopI = 1'b1;
    @(negedge clkI);
    checks++;
    if (stateO !== 3'd5 || phaseHiO !== 3'b000 || phaseLoO !== 3'b000 || workingO !== 1'b0) begin
      failures++;
      $display("FAIL fault_entry got state=%0d hi=%b lo=%b working=%b required 5 000 000 0",
               stateO, phaseHiO, phaseLoO, workingO);
    end
    faultI = 1'b0;
    stopI = 1'b0;
    startI = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clkI);
      if (stateO !== 3'd5 || (phaseHiO | phaseLoO) !== 3'b000) bad++;
    end
    startI = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL fault_hold got bad_cycles=%0d required=0", bad);
    end
    stopI = 1'b1;
    @(negedge clkI);
    stopI = 1'b0;
    checks++;
    if (stateO !== 3'd0) begin
      failures++;
      $display("FAIL fault_exit got=%0d required=0", stateO);
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] e_step [3] = '{3'd1, 3'd2, 3'd3};
    int         e_tick [3] = '{3, 4, 3};
    logic [2:0] e_st   [3] = '{3'd2, 3'd2, 3'd3};
    int zc, nt;
    bit ok;
    logic [2:0] hi, lo;
    start_motor(1'b1);
    for (int i = 0; i < 3; i++) wait_step(nt, ok);
    observe_window(zc, hi, lo);
    #2;
    nRstI = 1'b0;
    #1;
    checks++;
    if ({stateO, stepO, phaseHiO, phaseLoO, workingO} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got state=%0d step=%0d hi=%b lo=%b working=%b required all 0",
               stateO, stepO, phaseHiO, phaseLoO, workingO);
    end
    @(negedge clkI);
    nRstI = 1'b1;
    start_motor(1'b1);
    checks++;
    if (stateO !== 3'd1) begin
      failures++;
      $display("FAIL restart_entry got=%0d required=1", stateO);
    end
    for (int i = 0; i < 3; i++) begin
      wait_step(nt, ok);
      checks++;
      if (!ok || nt !== e_tick[i] || stepO !== e_step[i] || stateO !== e_st[i]) begin
        failures++;
        $display("FAIL restart_step%0d got ok=%0d ticks=%0d step=%0d state=%0d required ticks=%0d step=%0d state=%0d",
                 i, ok, nt, stepO, stateO, e_tick[i], e_step[i], e_st[i]);
      end
    end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (overlap_seen !== 0) begin
      failures++;
      $display("FAIL leg_overlap got overlap_cycles=%0d required=0", overlap_seen);
    end
  endtask

  initial begin
    test_reset;
    test_align;
    test_forward_ramp;
    test_stop;
    test_reverse;
    test_fault;
    test_async_reset;
    test_no_overlap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
